// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_if
// Description : Bundles the fetch stage's two handshake channels.
//               - Instruction-memory channel: a valid/ready request carrying
//                 the fetch address, and a one-cycle response pulse carrying
//                 the instruction word and a bus-error flag.
//               - Decode-facing channel: the held instruction and its PC,
//                 a retire handshake, and the next PC to load on retire.
//               Modport "master" is the fetch unit; "slave" is the
//               environment (memory system plus decode/next-PC logic).
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_fetch_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);

  // Instruction-memory request channel
  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [PC_WIDTH-1:0]   imem_req_addr_o;

  // Instruction-memory response channel (single-cycle pulse)
  logic                  imem_rsp_valid_i;
  logic [INST_WIDTH-1:0] imem_rsp_data_i;
  logic                  imem_rsp_err_i;

  // Decode/execute channel
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic [INST_WIDTH-1:0] inst_o;
  logic [PC_WIDTH-1:0]   pc_o;
  logic [PC_WIDTH-1:0]   pc_next_i;

  // Fetch unit side
  modport master (
    output imem_req_valid_o,
    input  imem_req_ready_i,
    output imem_req_addr_o,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    input  imem_rsp_err_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output pc_o,
    input  pc_next_i
  );

  // Memory system and downstream pipeline side
  modport slave (
    input  imem_req_valid_o,
    output imem_req_ready_i,
    input  imem_req_addr_o,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    output imem_rsp_err_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  pc_o,
    output pc_next_i
  );

endinterface : ifu_fetch_if
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch stage. Owns the architectural PC, issues
//               one instruction-memory request per instruction, holds the
//               returned instruction for decode, and on retirement loads the
//               PC from the downstream next-PC generator. Faults (bus error
//               on the response, misaligned next PC) park the unit in a
//               halted state that only reset leaves.
//
// Ports       :
//   clk_i          in   clock, all state updates on the rising edge
//   rst_n_i        in   asynchronous active-low reset
//   bus            ifc  ifu_fetch_if.master
//                       imem_req_valid_o/ready_i/addr_o  fetch request
//                       imem_rsp_valid_i/data_i/err_i    fetch response
//                       inst_valid_o/ready_i/inst_o/pc_o held instruction
//                       pc_next_i                        next PC on retire
//   halted_o       out  fetch is halted on a fault
//   fault_cause_o  out  0 none, 1 bus error, 2 misaligned next PC (sticky)
//   retired_cnt_o  out  retired-instruction counter, wraps
//
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                  CNT_WIDTH  = 32
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_n_i,
  ifu_fetch_if.master               bus,
  output logic                      halted_o,
  output logic [1:0]                fault_cause_o,
  output logic [CNT_WIDTH-1:0]      retired_cnt_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] C_CAUSE_NONE     = 2'd0;
  localparam logic [1:0] C_CAUSE_BUS_ERR  = 2'd1;
  localparam logic [1:0] C_CAUSE_MISALIGN = 2'd2;

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  // --------------------------------------------------------------------------
  // State encoding
  //   S_REQ   : request outstanding on the bus (valid held until accepted)
  //   S_WAIT  : request accepted, waiting for the response pulse
  //   S_VALID : instruction presented to decode until retired
  //   S_HALT  : fault taken; terminal until reset
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  // Architectural and held-instruction state
  logic [PC_WIDTH-1:0]     r_pc;
  logic [INST_WIDTH-1:0]   r_inst;
  logic [1:0]              r_cause;
  logic [CNT_WIDTH-1:0]    r_cnt;

  // Decoded per-cycle actions from the FSM
  logic                    w_req_valid;
  logic                    w_inst_valid;
  logic                    w_halted;
  logic                    w_rsp_take;     // capture response this cycle
  logic                    w_retire;       // instruction retires this cycle
  logic                    w_misaligned;   // next PC not word aligned

  // Only the two low bits matter: instructions are 32-bit aligned.
  assign w_misaligned = (bus.pc_next_i[1:0] != 2'b00);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and output decode
  //   Handshake inputs are only looked at in the state that owns them, so a
  //   stray response (e.g. one left over from before a reset) or an early
  //   retire strobe has no effect anywhere else.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_req_valid  = 1'b0;
    w_inst_valid = 1'b0;
    w_halted     = 1'b0;
    w_rsp_take   = 1'b0;
    w_retire     = 1'b0;

    case (r_state)
      S_REQ: begin
        w_req_valid = 1'b1;
        if (bus.imem_req_ready_i) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        // Being in WAIT already implies the acceptance edge has passed, so
        // a response can never be consumed in its own acceptance cycle.
        if (bus.imem_rsp_valid_i) begin
          w_rsp_take = 1'b1;
          if (bus.imem_rsp_err_i) begin
            w_state_nxt = S_HALT;
          end else begin
            w_state_nxt = S_VALID;
          end
        end
      end

      S_VALID: begin
        w_inst_valid = 1'b1;
        if (bus.inst_ready_i) begin
          w_retire = 1'b1;
          if (w_misaligned) begin
            w_state_nxt = S_HALT;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end

      S_HALT: begin
        w_halted = 1'b1;
      end

      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  //   - inst is captured on every accepted response, including an erroring
  //     one, so the faulting word is visible while halted.
  //   - A retire always counts, even when the next PC then faults: the
  //     instruction itself completed; only the redirect is refused.
  //   - On a misaligned redirect the PC is left alone so pc_o still names
  //     the instruction that produced the bad target.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_cause <= C_CAUSE_NONE;
      r_cnt   <= '0;
    end else begin
      if (w_rsp_take) begin
        r_inst <= bus.imem_rsp_data_i;
        if (bus.imem_rsp_err_i) begin
          r_cause <= C_CAUSE_BUS_ERR;
        end
      end

      if (w_retire) begin
        r_cnt <= r_cnt + C_CNT_ONE;
        if (w_misaligned) begin
          r_cause <= C_CAUSE_MISALIGN;
        end else begin
          r_pc <= bus.pc_next_i;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  //   The request address is the PC register itself, so it is stable for as
  //   long as valid is held waiting for ready.
  // --------------------------------------------------------------------------
  assign bus.imem_req_valid_o = w_req_valid;
  assign bus.imem_req_addr_o  = r_pc;
  assign bus.inst_valid_o     = w_inst_valid;
  assign bus.inst_o           = r_inst;
  assign bus.pc_o             = r_pc;

  assign halted_o      = w_halted;
  assign fault_cause_o = r_cause;
  assign retired_cnt_o = r_cnt;

endmodule : ifu_fetch
`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Fetch stage that sits directly upstream of the next-PC generator.
- Owns the architectural PC register and issues one instruction-memory request per instruction over a valid/ready request channel with a variable-latency response.
- Presents the fetched instruction and its PC to decode/execute.
- On retirement, loads the PC with the next-PC value computed downstream; also keeps a retired-instruction counter.

Parameters:
PC_WIDTH, 32, width of PC and memory address
INST_WIDTH, 32, width of fetched instruction word
RESET_PC, 32'h8000_0000, PC value loaded at reset
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, all state rising-edge
rst_n_i  in  1  asynchronous active-low reset
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  PC_WIDTH  fetch address (equals pc_o)
imem_rsp_valid_i  in  1  response data valid (one-cycle pulse)
imem_rsp_data_i  in  INST_WIDTH  response instruction word
imem_rsp_err_i  in  1  bus error on response, qualified by rsp_valid
inst_valid_o  out  1  instruction available to downstream
inst_ready_i  in  1  downstream retires current instruction
inst_o  out  INST_WIDTH  held instruction word
pc_o  out  PC_WIDTH  PC of held instruction
pc_next_i  in  PC_WIDTH  next PC from next-PC generator, sampled on retire
halted_o  out  1  fetch halted on fault
fault_cause_o  out  2  0 none, 1 bus error, 2 misaligned next PC
retired_cnt_o  out  CNT_WIDTH  count of retired instructions

Behaviour:
Reset:
- Asserting rst_n_i low acts immediately (asynchronous), including mid-transaction.
- Reset values: pc = RESET_PC, state = REQ, inst_o = 0, fault_cause_o = 0, retired_cnt_o = 0, inst_valid_o = 0, halted_o = 0.
- An outstanding memory response arriving after reset is ignored unless the state is WAIT.

States:
- REQ:
  - imem_req_valid_o = 1, imem_req_addr_o = pc.
  - On imem_req_ready_i = 1, go to WAIT.
  - Valid is held, with address stable, until accepted.
- WAIT:
  - imem_req_valid_o = 0.
  - On imem_rsp_valid_i, latch data into inst_o.
  - If imem_rsp_err_i, go to HALT with cause 1. Otherwise go to VALID.
  - Responses are never accepted in the same cycle as request acceptance.
  - Minimum request-accept to inst_valid_o latency is 2 cycles.
- VALID:
  - inst_valid_o = 1; inst_o and pc_o are stable.
  - On inst_ready_i = 1:
    - sample pc_next_i;
    - retired_cnt_o increments by 1, wrapping modulo 2^CNT_WIDTH.
  - If pc_next_i[1:0] != 0:
    - go to HALT with cause 2;
    - pc is not updated (pc_o keeps the faulting instruction's PC).
  - Otherwise pc <= pc_next_i and go to REQ.
- HALT:
  - All valids are 0, halted_o = 1, fault_cause_o is sticky.
  - Only reset exits HALT.

Signal rules:
- inst_ready_i is ignored outside VALID.
- imem_rsp_valid_i is ignored outside WAIT.
- pc_o always reflects the pc register.
- There is exactly one outstanding request at a time.
- PC arithmetic is not performed here; pc_next_i is used verbatim.

Test Plan:
- Reset release, memory always ready, response 1 cycle after accept with data 0x00000013:
  - imem_req_addr_o = 0x80000000.
  - inst_valid_o rises 2 cycles after accept with inst_o = 0x00000013.
  - inst_ready_i = 1 with pc_next_i = 0x80000004 → next request addr = 0x80000004, retired_cnt_o = 1.
- imem_req_ready_i held low 3 cycles:
  - req_valid stays 1 and addr is stable for 3 cycles.
  - WAIT is entered only on the ready cycle.
- inst_ready_i low 4 cycles in VALID:
  - inst_o and pc_o are stable and the counter does not move.
  - On retire with pc_next_i = 0x80000100, the next request addr = 0x80000100.
- Response with imem_rsp_err_i = 1:
  - halted_o = 1, fault_cause_o = 1, no further requests.
  - Reset returns pc to 0x80000000 and fault_cause_o to 0.
- Retire with pc_next_i = 0x80000102:
  - halted_o = 1, fault_cause_o = 2, pc_o unchanged, retired_cnt_o incremented.
- rst_n_i asserted in WAIT, then the stale response arrives 1 cycle after release:
  - the stale response is ignored while in REQ;
  - a fresh request to 0x80000000 is issued;
  - retired_cnt_o = 0.
